mc_control_fsm: RTL and testbench

Multicycle main control unit for the MIPS-subset processor. It sequences the shared datapath (PC, instruction/data memory port, register file, single ALU) through fetch, decode, execute, memory and writeback steps. It generates the 2-bit `alu_op` consumed by the ALU control decoder:

- `00`: add
- `01`: subtract
- `10`: decode funct
- `11`: or

It also drives all datapath mux selects, write enables and a retired-instruction counter.

---
 rtl/mc_control_fsm.sv | 207 ++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle main control unit for the MIPS-subset datapath.
// Sequences FETCH / DECODE / execute / memory / writeback states and drives
// every datapath mux select, write enable and the ALU-control alu_op code.
//
// Ports:
//   clk, reset_n            rising-edge clock, synchronous active-low reset
//   opcode[5:0]             IR[31:26], stable from DECODE to the next FETCH
//   zero                    ALU zero flag (qualifies pc_en in BRANCH)
//   mem_ready               memory handshake (only with MC_CTRL_MEM_WAIT_EN)
//   pc_en, ir_write         PC / IR load enables
//   mem_read, mem_write     memory strobes; i_or_d selects ALUOut as address
//   reg_write, reg_dst      register file write enable / rd select
//   mem_to_reg              writeback from MDR
//   alu_src_a, alu_src_b    ALU operand selects
//   zero_ext                zero-extend immediate (ori)
//   alu_op[1:0]             00 add, 01 sub, 10 funct, 11 or
//   pc_src[1:0]             00 ALU, 01 ALUOut, 10 jump target
//   illegal_op              unknown opcode seen in DECODE (1-cycle pulse)
//   state[3:0]              current state
//   instr_count[CNT_W-1:0]  retired-instruction counter (wraps)
//
// Build option: MC_CTRL_MEM_WAIT_EN makes FETCH, MEMRD and MEMWR hold until
// mem_ready; without it mem_ready is ignored and each memory state is 1 cycle.

module mc_control_fsm #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             zero_ext,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t           r_state;
  state_t           w_next;
  logic             w_mem_ok;
  logic             w_retire;
  logic [CNT_W-1:0] r_cnt;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign w_mem_ok = mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = mem_ready;
  assign w_mem_ok           = 1'b1;
`endif

  // Retire on the edge that leaves the final state of each instruction;
  // MEMWR only leaves once its access has completed.
  assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                    (r_state == S_BRANCH) || (r_state == S_IWB) ||
                    (r_state == S_JUMP) || ((r_state == S_MEMWR) && w_mem_ok);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next     = r_state;
    pc_en      = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    zero_ext   = 1'b0;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    illegal_op = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR/PC load only in the cycle the fetch data is valid.
        ir_write  = w_mem_ok;
        pc_en     = w_mem_ok;
        if (w_mem_ok) w_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:    w_next = S_MEMADR;
          OP_R:            w_next = S_EXEC;
          OP_BEQ:          w_next = S_BRANCH;
          OP_ADDI, OP_ORI: w_next = S_IEXEC;
          OP_J:            w_next = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            w_next     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (w_mem_ok) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (w_mem_ok) w_next = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        w_next    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en     = zero;
        w_next    = S_FETCH;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_ORI) begin
          alu_op   = 2'b11;
          zero_ext = 1'b1;
        end
        w_next = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
        w_next = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign state       = r_state;
  assign instr_count = r_cnt;

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;
  localparam int unsigned CW = 4;
`ifdef MC_CTRL_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [5:0]    opcode = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          pc_en, ir_write, mem_read, mem_write, i_or_d, reg_write;
  logic          reg_dst, mem_to_reg, alu_src_a, zero_ext, illegal_op;
  logic [1:0]    alu_src_b, alu_op, pc_src;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;

  mc_control_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .zero_ext(zero_ext),
    .alu_op(alu_op), .pc_src(pc_src), .illegal_op(illegal_op),
    .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    st;
    logic [16:0]   o;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef int iq_t[$];

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   model_cnt = 0;

  // Output bundle order: pc_en ir_write mem_read mem_write i_or_d reg_write
  // reg_dst mem_to_reg alu_src_a alu_src_b zero_ext alu_op pc_src illegal_op
  logic [16:0] act;
  assign act = {pc_en, ir_write, mem_read, mem_write, i_or_d, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, zero_ext, alu_op,
                pc_src, illegal_op};

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                      6'b001000, 6'b001101, 6'b000010};
  endfunction

  // State walk of one instruction, FETCH onward.
  function automatic iq_t phases(input logic [5:0] op);
    case (op)
      6'b100011: return '{1, 2, 3, 4, 5};
      6'b101011: return '{1, 2, 3, 6};
      6'b000000: return '{1, 2, 7, 8};
      6'b000100: return '{1, 2, 9};
      6'b001000: return '{1, 2, 10, 11};
      6'b001101: return '{1, 2, 10, 11};
      6'b000010: return '{1, 2, 12};
      default:   return '{1, 2};
    endcase
  endfunction

  function automatic logic [16:0] expect_out(input int s, input logic [5:0] op,
                                             input logic z, input logic rdy);
    logic pe, irw, mr, mw, iod, rw, rd, m2r, sa, zx, ill;
    logic [1:0] sb, aop, ps;
    {pe, irw, mr, mw, iod, rw, rd, m2r, sa, zx, ill} = '0;
    sb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (s)
      1: begin mr = 1; sb = 2'b01; irw = rdy; pe = rdy; end
      2: begin sb = 2'b11; ill = !is_legal(op); end
      3: begin sa = 1; sb = 2'b10; end
      4: begin mr = 1; iod = 1; end
      5: begin rw = 1; m2r = 1; end
      6: begin mw = 1; iod = 1; end
      7: begin sa = 1; aop = 2'b10; end
      8: begin rw = 1; rd = 1; end
      9: begin sa = 1; aop = 2'b01; ps = 2'b01; pe = z; end
      10: begin
        sa = 1; sb = 2'b10;
        if (op == 6'b001101) begin aop = 2'b11; zx = 1; end
      end
      11: rw = 1;
      12: begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {pe, irw, mr, mw, iod, rw, rd, m2r, sa, sb, zx, aop, ps, ill};
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show this cycle.
  task automatic cycle(input int s, input logic [5:0] op, input logic z,
                       input logic rdy, input logic rstn);
    exp_t e;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    reset_n   = rstn;
    e.st  = s[3:0];
    e.o   = expect_out(s, op, z, WAIT_EN ? rdy : 1'b1);
    e.cnt = model_cnt[CW-1:0];
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  function automatic logic pick_z(input int zmode);
    if (zmode == 2) return 1'($urandom_range(0, 1));
    return zmode[0];
  endfunction

  // abort_at: phase index whose cycle sees reset_n low (-1 = none).
  task automatic run_instr(input logic [5:0] op, input int zmode,
                           input int abort_at, input int fixed_wait);
    iq_t ph;
    int  nw;
    ph = phases(op);
    for (int i = 0; i < ph.size(); i++) begin
      if (WAIT_EN && (ph[i] inside {1, 4, 6})) begin
        nw = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        if (i == abort_at) begin
          cycle(ph[i], op, pick_z(zmode), 1'b0, 1'b0);
          model_cnt = 0;
          cycle(0, op, pick_z(zmode), 1'($urandom_range(0, 1)), 1'b1);
          return;
        end
        for (int w = 0; w < nw; w++) cycle(ph[i], op, pick_z(zmode), 1'b0, 1'b1);
      end
      if (i == abort_at) begin
        cycle(ph[i], op, pick_z(zmode), 1'($urandom_range(0, 1)), 1'b0);
        model_cnt = 0;
        cycle(0, op, pick_z(zmode), 1'($urandom_range(0, 1)), 1'b1);
        return;
      end
      cycle(ph[i], op, pick_z(zmode), WAIT_EN ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1);
    end
    if (is_legal(op)) model_cnt = (model_cnt + 1) % (1 << CW);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Monitor: the DUT presents a result every cycle; compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("state", 32'(state), 32'(e.st));
      chk("outputs", 32'(act), 32'(e.o));
      chk("instr_count", 32'(instr_count), 32'(e.cnt));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [5:0] ops [8];
    logic [5:0] op;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
            6'b001000, 6'b001101, 6'b000010, 6'b111111};
    repeat (2) @(posedge clk);
    #2;
    cycle(0, 6'b0, 1'b0, 1'b0, 1'b1);
    run_instr(6'b000000, 2, -1, -1);
    run_instr(6'b100011, 2, -1, 0);
    run_instr(6'b101011, 2, -1, 0);
    run_instr(6'b000100, 1, -1, 0);
    run_instr(6'b000100, 0, -1, 0);
    run_instr(6'b001000, 2, -1, 0);
    run_instr(6'b001101, 2, -1, 0);
    run_instr(6'b111111, 2, -1, 0);
    run_instr(6'b000000, 2, -1, 3);
    run_instr(6'b100011, 2, 3, 2);
    for (int n = 0; n < 20; n++) run_instr(6'b000010, 2, -1, -1);
    for (int n = 0; n < 160; n++) begin
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 7)];
      run_instr(op, 2, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1, -1);
    end
    @(posedge clk);
    @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
